execute_cycle: RTL and testbench
================================

Name: execute_cycle

Overview:
- Execute stage of the 5-stage RISC-V pipeline; consumes the D/E pipeline-register outputs (RegWriteE, ALUControlE, RD1_E, Imm_Ext_E, …).
- Applies operand forwarding, runs the ALU, resolves BEQ branches and computes the branch target.
- Registers results into the E/M pipeline register feeding the memory stage.
- Hazard unit supplies forwarding selects, flush and hold controls.

Parameters:
- XLEN, 32, datapath width
- RESET_PC4, 32'h00000000, reset value of PCPlus4M

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  in  1 each  control from D/E register
- ALUControlE  in  3  ALU operation
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  XLEN each  operands/PC from D/E register
- RD_E  in  5  destination register
- ForwardAE, ForwardBE  in  2 each  forward selects from hazard unit
- ALUResultM_fwd  in  XLEN  forwarded value from M stage
- ResultW  in  XLEN  forwarded value from W stage
- FlushM  in  1  insert bubble into E/M register
- HoldM  in  1  freeze E/M register
- PCSrcE  out  1  branch taken (combinational)
- PCTargetE  out  XLEN  branch target (combinational)
- RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered control
- RD_M  out  5  registered destination
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN each  registered data

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high. All E/M register updates occur on posedge clk only.
- Forward mux A (SrcAE):
  - ForwardAE 00 → RD1_E
  - ForwardAE 01 → ResultW
  - ForwardAE 10 → ALUResultM_fwd
  - ForwardAE 11 → RD1_E
- Forward mux B: ForwardBE selects WriteDataE using the same encoding, with RD2_E as the base value.
- SrcBE = ALUSrcE ? Imm_Ext_E : WriteDataE.
- ALU, XLEN-bit, wrap-around, no overflow flag:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT (signed; result 1 or 0, zero-extended)
  - 110 SLL by SrcBE[4:0]
  - 111 SRL (logical) by SrcBE[4:0]
- ZeroE = (ALUResultE == 0).
- Branch outputs (both purely combinational, zero latency):
  - PCSrcE = BranchE & ZeroE (BEQ semantics; branches issue ALUControlE=001).
  - PCTargetE = PCE + Imm_Ext_E, modulo 2^XLEN.
- E/M register update priority on each posedge clk:
  - rst=1 → all registered outputs cleared to 0, except PCPlus4M = RESET_PC4.
  - else FlushM=1 → RegWriteM=0 and MemWriteM=0; remaining fields load normally (a bubble with no architectural side effect).
  - else HoldM=1 → all registered outputs keep their value.
  - else → load RegWriteE, MemWriteE, ResultSrcE, RD_E, ALUResultE, WriteDataE, PCPlus4E.
- FlushM=1 and HoldM=1 together: flush wins.
- rst asserted mid-stream: the next edge clears the register regardless of FlushM/HoldM. Combinational PCSrcE/PCTargetE still follow their inputs during reset.
- Latency: one cycle from E inputs to M outputs.
- WriteDataM is the forwarded B operand (pre-ALUSrc mux), so stores carry forwarded data.
- The M-stage forwarding source is an input; there is no internal loop from ALUResultM.

Test Plan:
1. Reset: rst=1 for 2 cycles with random inputs → all M outputs 0, PCPlus4M=RESET_PC4; after release, first load appears one cycle later.
2. ADD/SUB/SLT, no forwarding:
   - RD1_E=5, RD2_E=7, ALUSrcE=0, ALUControlE=000 → ALUResultM=12 next cycle.
   - ALUControlE=001 → 32'hFFFFFFFE.
   - ALUControlE=101 with RD1_E=32'hFFFFFFFF, RD2_E=1 → 1.
3. Forwarding:
   - RD1_E=1, ResultW=100, ForwardAE=01, RD2_E=3, ALUResultM_fwd=50, ForwardBE=10, ALUControlE=000 → ALUResultM=150, WriteDataM=50.
   - ForwardAE=11 → operand A is RD1_E.
4. Branch:
   - BranchE=1, ALUControlE=001, RD1_E=RD2_E=9, PCE=32'h100, Imm_Ext_E=32'hFFFFFFF8 → PCSrcE=1, PCTargetE=32'hF8, same cycle.
   - RD2_E=8 → PCSrcE=0.
5. Immediate store:
   - MemWriteE=1, ALUSrcE=1, Imm_Ext_E=16, RD1_E=32'h1000, RD2_E=32'hABCD → ALUResultM=32'h1010, WriteDataM=32'hABCD, MemWriteM=1.
6. Hold/flush:
   - HoldM=1 for 3 cycles with changing inputs → outputs frozen.
   - FlushM=1 with HoldM=1 and RegWriteE=MemWriteE=1 → RegWriteM=0, MemWriteM=0.
   - rst=1 with FlushM=0, HoldM=1 → cleared.

Source files
------------

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, BEQ resolution/branch target, and the E/M pipeline register.
module execute_cycle #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC4 = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            ALUSrcE,
    input  logic            MemWriteE,
    input  logic            ResultSrcE,
    input  logic            BranchE,
    input  logic [2:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RD_E,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ALUResultM_fwd,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushM,
    input  logic            HoldM,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] write_data_e;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result_e;
    logic [4:0]      shamt;
    logic            zero_e;

    // Forwarding muxes; encoding 11 is unused by the hazard unit and falls back to the register value
    always_comb begin
        src_a = RD1_E;
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUResultM_fwd;
            default: src_a = RD1_E;
        endcase
        write_data_e = RD2_E;
        case (ForwardBE)
            2'b01:   write_data_e = ResultW;
            2'b10:   write_data_e = ALUResultM_fwd;
            default: write_data_e = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : write_data_e;
    assign shamt = src_b[4:0];

    always_comb begin
        alu_result_e = '0;
        case (ALUControlE)
            ALU_ADD: alu_result_e = src_a + src_b;
            ALU_SUB: alu_result_e = src_a - src_b;
            ALU_AND: alu_result_e = src_a & src_b;
            ALU_OR:  alu_result_e = src_a | src_b;
            ALU_XOR: alu_result_e = src_a ^ src_b;
            ALU_SLT: alu_result_e = ($signed(src_a) < $signed(src_b)) ? XLEN'(1) : '0;
            ALU_SLL: alu_result_e = src_a << shamt;
            ALU_SRL: alu_result_e = src_a >> shamt;
            default: alu_result_e = '0;
        endcase
    end

    assign zero_e    = (alu_result_e == '0);
    assign PCSrcE    = BranchE & zero_e;
    assign PCTargetE = PCE + Imm_Ext_E;

    // E/M register: reset > flush (bubble, data still loads) > hold > load
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            RD_M       <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= RESET_PC4;
        end else if (FlushM || !HoldM) begin
            RegWriteM  <= FlushM ? 1'b0 : RegWriteE;
            MemWriteM  <= FlushM ? 1'b0 : MemWriteE;
            ResultSrcM <= ResultSrcE;
            RD_M       <= RD_E;
            ALUResultM <= alu_result_e;
            WriteDataM <= write_data_e;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed, table-driven bench for execute_cycle plus hand sequences for reset, hold and flush.
module tb_execute_cycle;

    localparam logic [31:0] RST_PC4 = 32'hDEAD_0004;
    localparam logic [31:0] MF = 32'hAAAA_0000;
    localparam logic [31:0] RW = 32'h5555_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ALUResultM_fwd, ResultW;
    logic        FlushM, HoldM;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    execute_cycle #(.XLEN(32), .RESET_PC4(RST_PC4)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUResultM_fwd(ALUResultM_fwd), .ResultW(ResultW), .FlushM(FlushM), .HoldM(HoldM),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RD_M(RD_M), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        br, alus, mw, rw, rs;
        logic [2:0]  op;
        logic [1:0]  fa, fb;
        logic [4:0]  rd;
        logic [31:0] rd1, rd2, imm, pce, mfwd, resw;
        logic [31:0] exp_alu, exp_wd;
        logic        exp_pcsrc;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic br, alus, mw, rw, rs, input logic [2:0] op,
                                input logic [1:0] fa, fb, input logic [4:0] rd,
                                input logic [31:0] rd1, rd2, imm, pce, mfwd, resw,
                                input logic [31:0] ealu, ewd, input logic epc,
                                input logic [31:0] etgt);
        vec_t v;
        v.br = br; v.alus = alus; v.mw = mw; v.rw = rw; v.rs = rs; v.op = op;
        v.fa = fa; v.fb = fb; v.rd = rd; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm;
        v.pce = pce; v.mfwd = mfwd; v.resw = resw; v.exp_alu = ealu; v.exp_wd = ewd;
        v.exp_pcsrc = epc; v.exp_tgt = etgt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic [31:0] pcp4);
        BranchE = v.br; ALUSrcE = v.alus; MemWriteE = v.mw; RegWriteE = v.rw;
        ResultSrcE = v.rs; ALUControlE = v.op; ForwardAE = v.fa; ForwardBE = v.fb;
        RD_E = v.rd; RD1_E = v.rd1; RD2_E = v.rd2; Imm_Ext_E = v.imm; PCE = v.pce;
        ALUResultM_fwd = v.mfwd; ResultW = v.resw; PCPlus4E = pcp4;
    endtask

    task automatic chk_m(input string tag, input logic rw, mw, rs, input logic [4:0] rd,
                         input logic [31:0] alu, wd, pcp4);
        chk({tag, ".RegWriteM"},  32'(RegWriteM),  32'(rw));
        chk({tag, ".MemWriteM"},  32'(MemWriteM),  32'(mw));
        chk({tag, ".ResultSrcM"}, 32'(ResultSrcM), 32'(rs));
        chk({tag, ".RD_M"},       32'(RD_M),       32'(rd));
        chk({tag, ".ALUResultM"}, ALUResultM, alu);
        chk({tag, ".WriteDataM"}, WriteDataM, wd);
        chk({tag, ".PCPlus4M"},   PCPlus4M,   pcp4);
    endtask

    initial begin
        vec_t v;
        logic [31:0] pcp4;
        string tag;

        // br alus mw rw rs op fa fb rd rd1 rd2 imm pce mfwd resw | alu wd pcsrc tgt
        vecs.push_back(mk(0,0,0,1,0,3'b000,2'b00,2'b00,5, 32'd5,32'd7,0,0,MF,RW, 32'd12,32'd7,0,0));
        vecs.push_back(mk(0,0,0,1,0,3'b001,2'b00,2'b00,6, 32'd5,32'd7,0,0,MF,RW, 32'hFFFFFFFE,32'd7,0,0));
        vecs.push_back(mk(0,0,0,1,1,3'b101,2'b00,2'b00,7, 32'hFFFFFFFF,32'd1,0,0,MF,RW, 32'd1,32'd1,0,0));
        vecs.push_back(mk(0,0,0,1,0,3'b101,2'b00,2'b00,8, 32'd5,32'hFFFFFFFF,0,0,MF,RW, 32'd0,32'hFFFFFFFF,0,0));
        vecs.push_back(mk(0,0,0,1,0,3'b000,2'b01,2'b10,9, 32'd1,32'd3,0,0,32'd50,32'd100, 32'd150,32'd50,0,0));
        vecs.push_back(mk(0,0,0,1,0,3'b000,2'b11,2'b01,10,32'd1,32'd3,0,0,32'd50,32'd100, 32'd101,32'd100,0,0));
        vecs.push_back(mk(0,0,0,1,0,3'b000,2'b10,2'b11,11,32'd1,32'd3,0,0,32'd50,32'd100, 32'd53,32'd3,0,0));
        vecs.push_back(mk(1,0,0,0,0,3'b001,2'b00,2'b00,0, 32'd9,32'd9,32'hFFFFFFF8,32'h100,MF,RW, 32'd0,32'd9,1,32'hF8));
        vecs.push_back(mk(1,0,0,0,0,3'b001,2'b00,2'b00,0, 32'd9,32'd8,32'hFFFFFFF8,32'h100,MF,RW, 32'd1,32'd8,0,32'hF8));
        vecs.push_back(mk(0,1,1,0,0,3'b000,2'b00,2'b00,0, 32'h1000,32'hABCD,32'd16,32'h20,MF,RW, 32'h1010,32'hABCD,0,32'h30));
        vecs.push_back(mk(0,0,0,1,0,3'b010,2'b00,2'b00,12,32'hF0F0,32'h0FF0,0,0,MF,RW, 32'h00F0,32'h0FF0,0,0));
        vecs.push_back(mk(0,0,0,1,0,3'b011,2'b00,2'b00,13,32'hF0F0,32'h0FF0,0,0,MF,RW, 32'hFFF0,32'h0FF0,0,0));
        vecs.push_back(mk(0,0,0,1,0,3'b100,2'b00,2'b00,14,32'hF0F0,32'h0FF0,0,0,MF,RW, 32'hFF00,32'h0FF0,0,0));
        vecs.push_back(mk(0,1,0,1,0,3'b110,2'b00,2'b00,15,32'd1,32'h77,32'h24,0,MF,RW, 32'h10,32'h77,0,32'h24));
        vecs.push_back(mk(0,0,0,1,0,3'b111,2'b00,2'b00,16,32'h80000000,32'd31,0,0,MF,RW, 32'd1,32'd31,0,0));
        vecs.push_back(mk(0,0,0,1,0,3'b111,2'b00,2'b00,17,32'hF0000000,32'd4,0,0,MF,RW, 32'h0F000000,32'd4,0,0));
        vecs.push_back(mk(0,0,0,1,0,3'b001,2'b00,2'b00,18,32'd4,32'd4,0,0,MF,RW, 32'd0,32'd4,0,0));
        vecs.push_back(mk(0,0,0,1,0,3'b000,2'b00,2'b00,19,32'hFFFFFFFF,32'd2,0,0,MF,RW, 32'd1,32'd2,0,0));

        // Reset with random inputs; combinational branch logic keeps following inputs
        rst = 1'b1;
        drive(mk(1'($urandom),1'($urandom),1'($urandom),1'($urandom),1'($urandom),3'($urandom),
                 2'($urandom),2'($urandom),5'($urandom),$urandom,$urandom,$urandom,$urandom,
                 $urandom,$urandom,0,0,0,0), $urandom);
        FlushM = 1'($urandom); HoldM = 1'($urandom);
        repeat (2) @(posedge clk);
        #1;
        chk_m("reset", 0, 0, 0, 5'd0, 32'd0, 32'd0, RST_PC4);
        PCE = 32'h40; Imm_Ext_E = 32'h8;
        #1;
        chk("reset.PCTargetE", PCTargetE, 32'h48);

        // First load after release
        @(posedge clk); #1;
        rst = 1'b0; FlushM = 1'b0; HoldM = 1'b0;
        drive(vecs[0], 32'h200);
        #1;
        chk("release.before_edge.ALUResultM", ALUResultM, 32'd0);

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            pcp4 = 32'h200 + 32'(i) * 32'd4;
            tag = $sformatf("vec%0d", i);
            drive(v, pcp4);
            #1;
            chk({tag, ".PCSrcE"},    32'(PCSrcE), 32'(v.exp_pcsrc));
            chk({tag, ".PCTargetE"}, PCTargetE,   v.exp_tgt);
            @(posedge clk); #1;
            chk_m(tag, v.rw, v.mw, v.rs, v.rd, v.exp_alu, v.exp_wd, pcp4);
        end

        // Hold: load a known value, then freeze for 3 cycles while inputs change
        drive(mk(0,0,0,1,1,3'b000,2'b00,2'b00,7, 32'd20,32'd22,0,0,MF,RW, 0,0,0,0), 32'h300);
        @(posedge clk); #1;
        chk_m("hold.load", 1, 0, 1, 5'd7, 32'd42, 32'd22, 32'h300);
        HoldM = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(mk(0,0,1,0,0,3'b001,2'b00,2'b00,5'(20 + k), 32'(100 + k),32'd1,0,0,MF,RW, 0,0,0,0),
                  32'h500 + 32'(k));
            @(posedge clk); #1;
            chk_m($sformatf("hold%0d", k), 1, 0, 1, 5'd7, 32'd42, 32'd22, 32'h300);
        end

        // Flush beats hold: bubble controls, data fields still load
        FlushM = 1'b1;
        drive(mk(0,0,1,1,1,3'b000,2'b00,2'b00,9, 32'd2,32'd3,0,0,MF,RW, 0,0,0,0), 32'h400);
        @(posedge clk); #1;
        chk_m("flush_hold", 0, 0, 1, 5'd9, 32'd5, 32'd3, 32'h400);

        // Reset beats hold mid-stream; branch output still live
        FlushM = 1'b0; HoldM = 1'b1; rst = 1'b1;
        drive(mk(1,0,1,1,1,3'b001,2'b00,2'b00,3, 32'd6,32'd6,32'h10,32'h80,MF,RW, 0,0,0,0), 32'h600);
        #1;
        chk("rst_hold.PCSrcE", 32'(PCSrcE), 32'd1);
        @(posedge clk); #1;
        chk_m("rst_hold", 0, 0, 0, 5'd0, 32'd0, 32'd0, RST_PC4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
